// File: rtl/sprite_engine.sv
// Multi-sprite line renderer: per-line bitmap row prefetch, then per-pixel priority and registered RGB.
// Optional x2 scaling is compiled in with SPRITE_ENGINE_SCALE_EN.
module sprite_engine #(
  parameter int CORDW   = 16,
  parameter int NUM_SPR = 4,
  parameter int SPR_W   = 8,
  parameter int SPR_H   = 8,
  localparam int SW = (NUM_SPR > 1) ? $clog2(NUM_SPR) : 1,
  localparam int RW = (SPR_H > 1) ? $clog2(SPR_H) : 1
) (
  input  logic                    i_clk_25,
  input  logic                    i_rst_n,
  input  logic                    i_line,
  input  logic signed [CORDW-1:0] i_sy,
  input  logic signed [CORDW-1:0] i_sx,
  input  logic                    i_de,
  input  logic                    i_cfg_we,
  input  logic [SW-1:0]           i_cfg_sel,
  input  logic signed [CORDW-1:0] i_cfg_x,
  input  logic signed [CORDW-1:0] i_cfg_y,
  input  logic [23:0]             i_cfg_rgb,
  input  logic                    i_cfg_en,
  input  logic                    i_cfg_scale,
  input  logic                    i_bmp_we,
  input  logic [SW-1:0]           i_bmp_sel,
  input  logic [RW-1:0]           i_bmp_row,
  input  logic [SPR_W-1:0]        i_bmp_data,
  output logic [7:0]              o_r,
  output logic [7:0]              o_g,
  output logic [7:0]              o_b,
  output logic                    o_pix,
  output logic [SW-1:0]           o_spr_id,
  output logic                    o_busy
);
  localparam int CW = (SPR_W > 1) ? $clog2(SPR_W) : 1;
  localparam logic signed [CORDW:0] H1 = (CORDW+1)'(SPR_H);
  localparam logic signed [CORDW:0] H2 = (CORDW+1)'(2 * SPR_H);
  localparam logic signed [CORDW:0] W1 = (CORDW+1)'(SPR_W);
  localparam logic signed [CORDW:0] W2 = (CORDW+1)'(2 * SPR_W);

  typedef enum logic {IDLE, FETCH} state_t;
  state_t                  state_q, state_d;
  logic [SW-1:0]           fidx_q, fidx_d;
  logic signed [CORDW-1:0] sy_q, sy_d;
  logic                    fetch_go;

  logic signed [CORDW-1:0] x_q   [NUM_SPR];
  logic signed [CORDW-1:0] y_q   [NUM_SPR];
  logic [23:0]             rgb_q [NUM_SPR];
  logic [NUM_SPR-1:0]      en_q;
  logic [NUM_SPR-1:0]      scale_w;
  logic [SPR_W-1:0]        bmp_q [NUM_SPR][SPR_H];
  logic [SPR_W-1:0]        lbuf_q [NUM_SPR];
  logic [NUM_SPR-1:0]      rv_q;

`ifdef SPRITE_ENGINE_SCALE_EN
  logic [NUM_SPR-1:0] scale_q;
  always_ff @(posedge i_clk_25 or negedge i_rst_n) begin
    if (!i_rst_n)      scale_q <= '0;
    else if (i_cfg_we) scale_q[i_cfg_sel] <= i_cfg_scale;
  end
  assign scale_w = scale_q;
`else
  logic unused_cfg_scale;
  assign unused_cfg_scale = i_cfg_scale;
  assign scale_w = '0;
`endif

  always_ff @(posedge i_clk_25 or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      fidx_q  <= '0;
      sy_q    <= '0;
    end else begin
      state_q <= state_d;
      fidx_q  <= fidx_d;
      sy_q    <= sy_d;
    end
  end

  // A new line strobe always wins, restarting the walk from sprite 0.
  always_comb begin
    state_d  = state_q;
    fidx_d   = fidx_q;
    sy_d     = sy_q;
    fetch_go = 1'b0;
    if (i_line) begin
      state_d = FETCH;
      fidx_d  = '0;
      sy_d    = i_sy;
    end else if (state_q == FETCH) begin
      fetch_go = 1'b1;
      if (fidx_q == SW'(NUM_SPR - 1)) begin
        state_d = IDLE;
        fidx_d  = '0;
      end else begin
        fidx_d = fidx_q + 1'b1;
      end
    end
  end

  logic signed [CORDW:0] fd;
  logic                  fscale;
  logic                  fhit;
  logic [RW-1:0]         frow_idx;
  logic [SPR_W-1:0]      frow;
  always_comb begin
    fscale   = scale_w[fidx_q];
    fd       = {sy_q[CORDW-1], sy_q} - {y_q[fidx_q][CORDW-1], y_q[fidx_q]};
    fhit     = en_q[fidx_q] && !fd[CORDW] && (fd < (fscale ? H2 : H1));
    frow_idx = fscale ? fd[RW:1] : fd[RW-1:0];
    frow     = bmp_q[fidx_q][frow_idx];
  end

  // The fetch reads bmp_q before this cycle's bitmap write lands.
  always_ff @(posedge i_clk_25 or negedge i_rst_n) begin
    if (!i_rst_n) begin
      en_q <= '0;
      rv_q <= '0;
      for (int i = 0; i < NUM_SPR; i++) begin
        x_q[i]    <= '0;
        y_q[i]    <= '0;
        rgb_q[i]  <= '0;
        lbuf_q[i] <= '0;
        for (int j = 0; j < SPR_H; j++) bmp_q[i][j] <= '0;
      end
    end else begin
      if (i_cfg_we) begin
        x_q[i_cfg_sel]   <= i_cfg_x;
        y_q[i_cfg_sel]   <= i_cfg_y;
        rgb_q[i_cfg_sel] <= i_cfg_rgb;
        en_q[i_cfg_sel]  <= i_cfg_en;
      end
      if (i_bmp_we) bmp_q[i_bmp_sel][i_bmp_row] <= i_bmp_data;
      if (fetch_go) begin
        rv_q[fidx_q] <= fhit;
        if (fhit) lbuf_q[fidx_q] <= frow;
      end
    end
  end

  logic [NUM_SPR-1:0] hit;
  for (genvar gi = 0; gi < NUM_SPR; gi++) begin : g_draw
    logic signed [CORDW:0] c;
    logic [CW-1:0]         col;
    assign c   = {i_sx[CORDW-1], i_sx} - {x_q[gi][CORDW-1], x_q[gi]};
    assign col = CW'(SPR_W - 1) - (scale_w[gi] ? c[CW:1] : c[CW-1:0]);
    assign hit[gi] = rv_q[gi] && en_q[gi] && !c[CORDW] &&
                     (c < (scale_w[gi] ? W2 : W1)) && lbuf_q[gi][col];
  end

  logic [SW-1:0] win;
  always_comb begin
    win = '0;
    for (int i = NUM_SPR - 1; i >= 0; i--) begin
      if (hit[i]) win = SW'(i);
    end
  end

  logic [23:0]   rgb_out_q;
  logic          pix_q;
  logic [SW-1:0] id_q;
  always_ff @(posedge i_clk_25 or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rgb_out_q <= '0;
      pix_q     <= 1'b0;
      id_q      <= '0;
    end else if (i_de && (|hit)) begin
      rgb_out_q <= rgb_q[win];
      pix_q     <= 1'b1;
      id_q      <= win;
    end else begin
      rgb_out_q <= '0;
      pix_q     <= 1'b0;
      id_q      <= '0;
    end
  end

  assign o_r      = rgb_out_q[23:16];
  assign o_g      = rgb_out_q[15:8];
  assign o_b      = rgb_out_q[7:0];
  assign o_pix    = pix_q;
  assign o_spr_id = id_q;
  assign o_busy   = (state_q == FETCH);
endmodule

// File: tb/tb_sprite_engine.sv
// Self-checking bench for sprite_engine: scene tables, hand-written fetch corner cases and
// randomized scenes compared against a per-pixel geometric model.
module tb_sprite_engine;
  localparam int NS    = 4;
  localparam int HA    = 40;
  localparam int BLANK = 8;
`ifdef SPRITE_ENGINE_SCALE_EN
  localparam bit SC_EN = 1'b1;
`else
  localparam bit SC_EN = 1'b0;
`endif

  logic               i_clk_25 = 1'b0;
  logic               i_rst_n;
  logic               i_line, i_de;
  logic signed [15:0] i_sy, i_sx, i_cfg_x, i_cfg_y;
  logic               i_cfg_we, i_cfg_en, i_cfg_scale, i_bmp_we;
  logic [1:0]         i_cfg_sel, i_bmp_sel;
  logic [23:0]        i_cfg_rgb;
  logic [2:0]         i_bmp_row;
  logic [7:0]         i_bmp_data;
  logic [7:0]         o_r, o_g, o_b;
  logic               o_pix, o_busy;
  logic [1:0]         o_spr_id;

  sprite_engine dut (
    .i_clk_25(i_clk_25), .i_rst_n(i_rst_n), .i_line(i_line), .i_sy(i_sy), .i_sx(i_sx),
    .i_de(i_de), .i_cfg_we(i_cfg_we), .i_cfg_sel(i_cfg_sel), .i_cfg_x(i_cfg_x),
    .i_cfg_y(i_cfg_y), .i_cfg_rgb(i_cfg_rgb), .i_cfg_en(i_cfg_en), .i_cfg_scale(i_cfg_scale),
    .i_bmp_we(i_bmp_we), .i_bmp_sel(i_bmp_sel), .i_bmp_row(i_bmp_row), .i_bmp_data(i_bmp_data),
    .o_r(o_r), .o_g(o_g), .o_b(o_b), .o_pix(o_pix), .o_spr_id(o_spr_id), .o_busy(o_busy)
  );

  always #20 i_clk_25 = ~i_clk_25;

  int checks = 0;
  int passes = 0;

  int          m_x [NS];
  int          m_y [NS];
  logic [23:0] m_rgb [NS];
  bit          m_en [NS];
  bit          m_sc [NS];
  logic [7:0]  m_bmp [NS][8];
  logic [26:0] act_q [32][HA];

  typedef struct {
    int          scene;
    int          sx;
    int          sy;
    logic        pix;
    logic [23:0] rgb;
    logic [1:0]  id;
  } vec_t;
  vec_t vecs[$];

  task automatic tick();
    @(posedge i_clk_25);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s actual=%h required=%h", name, act, exp);
  endtask

  function automatic logic [26:0] model_px(input int sx, input int sy);
    for (int i = 0; i < NS; i++) begin
      int s, dx, dy;
      s  = (SC_EN && m_sc[i]) ? 2 : 1;
      dx = sx - m_x[i];
      dy = sy - m_y[i];
      if (m_en[i] && dx >= 0 && dx < 8 * s && dy >= 0 && dy < 8 * s &&
          m_bmp[i][dy / s][7 - dx / s])
        return {1'b1, m_rgb[i], 2'(i)};
    end
    return '0;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NS; i++) begin
      m_x[i] = 0; m_y[i] = 0; m_rgb[i] = '0; m_en[i] = 0; m_sc[i] = 0;
      for (int r = 0; r < 8; r++) m_bmp[i][r] = '0;
    end
  endtask

  task automatic wr(input bit cwe, input int sel, input int x, input int y,
                    input logic [23:0] rgb, input bit en, input bit sc,
                    input bit bwe, input int bsel, input int row, input logic [7:0] data);
    i_cfg_we = cwe; i_cfg_sel = 2'(sel); i_cfg_x = 16'(x); i_cfg_y = 16'(y);
    i_cfg_rgb = rgb; i_cfg_en = en; i_cfg_scale = sc;
    i_bmp_we = bwe; i_bmp_sel = 2'(bsel); i_bmp_row = 3'(row); i_bmp_data = data;
    tick();
    i_cfg_we = 1'b0; i_bmp_we = 1'b0;
    if (cwe) begin
      m_x[sel] = x; m_y[sel] = y; m_rgb[sel] = rgb; m_en[sel] = en; m_sc[sel] = sc;
    end
    if (bwe) m_bmp[bsel][row] = data;
  endtask

  // Row 0 goes out in the same cycle as the attribute write.
  task automatic set_spr(input int sel, input int x, input int y, input logic [23:0] rgb,
                         input bit en, input bit sc, input logic [63:0] rows);
    wr(1, sel, x, y, rgb, en, sc, 1, sel, 0, rows[63:56]);
    for (int r = 1; r < 8; r++) wr(0, 0, 0, 0, '0, 0, 0, 1, sel, r, rows[63 - 8 * r -: 8]);
  endtask

  task automatic clear_all();
    for (int i = 0; i < NS; i++) set_spr(i, 0, 0, '0, 0, 0, '0);
  endtask

  task automatic scan(input int sy);
    int lit, errs;
    logic [26:0] got, exp;
    lit = 0; errs = 0;
    i_de = 1'b0;
    for (int k = 0; k < BLANK; k++) tick();
    chk("busy_idle", {63'd0, o_busy}, 64'd0);
    for (int sx = 0; sx <= HA; sx++) begin
      if (sx < HA) begin i_sx = 16'(sx); i_de = 1'b1; end
      else i_de = 1'b0;
      tick();
      got = {o_pix, o_r, o_g, o_b, o_spr_id};
      if (sx < HA) begin
        exp = model_px(sx, sy);
        if (sy >= 0 && sy < 32) act_q[sy][sx] = got;
        if (got !== exp) errs++;
        if (got[26]) lit++;
        chk($sformatf("pixel(%0d,%0d)", sx, sy), {37'd0, got}, {37'd0, exp});
      end else begin
        chk("de_low", {37'd0, got}, 64'd0);
      end
    end
    i_sx = -16'sd8;
    $display("line sy=%0d lit=%0d errs=%0d", sy, lit, errs);
  endtask

  task automatic render_line(input int sy);
    i_line = 1'b1; i_sy = 16'(sy);
    tick();
    i_line = 1'b0;
    scan(sy);
  endtask

  task automatic check_table(input int scene);
    foreach (vecs[i]) begin
      if (vecs[i].scene == scene)
        chk($sformatf("vec s%0d (%0d,%0d)", scene, vecs[i].sx, vecs[i].sy),
            {37'd0, act_q[vecs[i].sy][vecs[i].sx]},
            {37'd0, vecs[i].pix, vecs[i].rgb, vecs[i].id});
    end
  endtask

  function automatic vec_t mk(input int scene, input int sx, input int sy, input logic pix,
                              input logic [23:0] rgb, input logic [1:0] id);
    vec_t v;
    v.scene = scene; v.sx = sx; v.sy = sy; v.pix = pix; v.rgb = rgb; v.id = id;
    return v;
  endfunction

  initial begin
    vecs.push_back(mk(2, 16, 16, 1, 24'hFFFF00, 0));
    vecs.push_back(mk(2, 23, 23, 1, 24'hFFFF00, 0));
    vecs.push_back(mk(2, 24, 16, 0, 24'h0, 0));
    vecs.push_back(mk(2, 15, 16, 0, 24'h0, 0));
    vecs.push_back(mk(2, 16, 24, 0, 24'h0, 0));
    vecs.push_back(mk(2, 16, 15, 0, 24'h0, 0));
    vecs.push_back(mk(3, 21, 21, 1, 24'hFF0000, 0));
    vecs.push_back(mk(3, 16, 16, 1, 24'h00FF00, 1));
    vecs.push_back(mk(3, 27, 27, 1, 24'hFF0000, 0));
    vecs.push_back(mk(4, 0, 0, 1, 24'h0000FF, 0));
    vecs.push_back(mk(4, 1, 0, 0, 24'h0, 0));
    vecs.push_back(mk(5, 0, 0, 1, 24'hFFFFFF, 0));
    vecs.push_back(mk(5, 2, 0, 0, 24'h0, 0));
    vecs.push_back(mk(5, 1, 0, SC_EN, SC_EN ? 24'hFFFFFF : 24'h0, 0));
    vecs.push_back(mk(5, 0, 1, SC_EN, SC_EN ? 24'hFFFFFF : 24'h0, 0));
    vecs.push_back(mk(5, 1, 1, SC_EN, SC_EN ? 24'hFFFFFF : 24'h0, 0));
    vecs.push_back(mk(5, 0, 2, 0, 24'h0, 0));
    vecs.push_back(mk(6, 5, 5, 1, 24'h00FFFF, 0));
    vecs.push_back(mk(6, 2, 5, 0, 24'h0, 0));

    i_rst_n = 1'b0; i_line = 1'b0; i_de = 1'b0; i_sx = -16'sd8; i_sy = '0;
    i_cfg_we = 0; i_cfg_sel = '0; i_cfg_x = '0; i_cfg_y = '0; i_cfg_rgb = '0;
    i_cfg_en = 0; i_cfg_scale = 0; i_bmp_we = 0; i_bmp_sel = '0; i_bmp_row = '0;
    i_bmp_data = '0;
    model_clear();
    for (int k = 0; k < 3; k++) tick();
    chk("reset_out", {37'd0, o_pix, o_r, o_g, o_b, o_spr_id, o_busy}, 64'd0);
    i_rst_n = 1'b1;

    // 1: blank frame after reset
    for (int sy = 0; sy < 24; sy++) render_line(sy);

    // 2: single sprite
    set_spr(0, 16, 16, 24'hFFFF00, 1, 0, {8{8'hFF}});
    for (int sy = 12; sy < 28; sy++) render_line(sy);
    check_table(2);

    // 3: priority
    set_spr(0, 20, 20, 24'hFF0000, 1, 0, {8{8'hFF}});
    set_spr(1, 16, 16, 24'h00FF00, 1, 0, {8{8'hFF}});
    for (int sy = 14; sy < 30; sy++) render_line(sy);
    check_table(3);

    // 4: clipping at negative x
    clear_all();
    set_spr(0, -7, 0, 24'h0000FF, 1, 0, {8'h81, 56'd0});
    render_line(0);
    render_line(1);
    check_table(4);

    // 5: scaling
    clear_all();
    set_spr(0, 0, 0, 24'hFFFFFF, 1, 1, {8'h80, 56'd0});
    for (int sy = 0; sy < 4; sy++) render_line(sy);
    check_table(5);

    // 6: line strobe during fetch restarts with the new line
    clear_all();
    set_spr(0, 0, 0, 24'h00FFFF, 1, 0, 64'h8040201008040201);
    i_line = 1'b1; i_sy = 16'sd2; tick();
    i_line = 1'b0; tick();
    chk("busy_first", {63'd0, o_busy}, 64'd1);
    i_line = 1'b1; i_sy = 16'sd5; tick();
    i_line = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("busy_restart%0d", k), {63'd0, o_busy}, 64'd1);
      tick();
    end
    chk("busy_done", {63'd0, o_busy}, 64'd0);
    scan(5);
    check_table(6);

    // bitmap write to the row being fetched: fetch sees old row, write lands
    set_spr(0, 0, 0, 24'h123456, 1, 0, {8{8'hFF}});
    i_line = 1'b1; i_sy = 16'sd0; tick();
    i_line = 1'b0;
    i_bmp_we = 1'b1; i_bmp_sel = 2'd0; i_bmp_row = 3'd0; i_bmp_data = 8'h0F;
    tick();
    i_bmp_we = 1'b0;
    scan(0);
    m_bmp[0][0] = 8'h0F;
    render_line(0);

    // randomized scenes
    for (int s = 0; s < 3; s++) begin
      for (int i = 0; i < NS; i++)
        set_spr(i, int'($urandom_range(0, 50)) - 10, int'($urandom_range(0, 40)) - 10,
                24'($urandom), ($urandom_range(0, 3) != 0), 1'($urandom),
                {$urandom, $urandom});
      for (int sy = 0; sy < 32; sy++) render_line(sy);
    end

    // reset in the middle of a fetch
    set_spr(0, 0, 0, 24'hABCDEF, 1, 0, {8{8'hFF}});
    render_line(3);
    i_line = 1'b1; i_sy = 16'sd4; tick();
    i_line = 1'b0; tick();
    i_rst_n = 1'b0;
    #1;
    chk("busy_rst", {63'd0, o_busy}, 64'd0);
    tick();
    i_rst_n = 1'b1;
    model_clear();
    scan(4);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #20ms;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end
endmodule
